control_flow_resolver: RTL and testbench
========================================

// Module: control_flow_resolver
// PURPOSE
//  Decode-stage partner of InstructoinFetch: latches fetched instruction/PC4,
//  decodes control-flow opcodes, drives SIG_* redirect strobes and target
//  addresses back to fetch. Owns a return-address stack (RAS) for CALL/RET.
//  Squashes the single wrong-path instruction fetched behind a taken redirect.
// PARAMETERS
//  RAS_DEPTH  8  return-address stack entries (power of 2, >=2)
//  AW         32 address/data width
// PORTS
//  clk            in  1   rising-edge clock
//  reset          in  1   asynchronous, active-low reset
//  instruction    in  32  word from fetch
//  PC4            in  AW  address of fetched instruction + 4
//  rs1Data        in  AW  register-file value of rs1 (of latched instr)
//  rs2Data        in  AW  register-file value of rs2 (of latched instr)
//  SIG_Jump       out 1   unconditional jump taken
//  SIG_Call       out 1   PC-relative call taken
//  SIG_CALL_RS1   out 1   register-indirect call taken
//  SIG_RET        out 1   return taken
//  SIG_BEQ        out 1   latched instr is BEQ
//  SIG_BNE        out 1   latched instr is BNE
//  SIG_EQ         out 1   rs1Data == rs2Data
//  jumpAddress    out AW  J/CALL target
//  branchAddress  out AW  BEQ/BNE target
//  callRs1Address out AW  rs1Data
//  returnAddress  out AW  RAS top-of-stack
//  idValid        out 1   latched instruction is live (not squashed)
// BEHAVIOUR
//  - Encoding: op=[31:26], rs1=[25:21], rs2=[20:16], imm16=[15:0], off26=[25:0].
//    J=6'h01 CALL=6'h02 BEQ=6'h03 BNE=6'h04 RET=6'h05 CALLR=6'h06; else non-CF.
//  - ID register: edge N captures instruction/PC4; SIG_* decoded combinationally
//    from it during cycle N; fetch redirects at edge N+1. 1-cycle decode latency.
//  - All SIG_* and idValid gated by idValid; squashed instr drives all SIG_* 0.
//  - Targets: jumpAddress={PC4[31:28],off26,2'b00};
//    branchAddress=PC4+{{14{imm16[15]}},imm16,2'b00} (mod 2^AW, wrap silently).
//  - Taken = J|CALL|CALLR|RET | (BEQ&EQ) | (BNE&~EQ).
//  - FSM: RUN -> FLUSH on taken valid instr (at edge N+1, capture with idValid=0);
//    FLUSH -> RUN unconditionally next edge. Taken never evaluated in FLUSH.
//  - RAS: CALL/CALLR push latched PC4 at edge N+1; RET pops at edge N+1.
//    returnAddress = entry[sp-1], combinational; only valid instrs touch RAS.
//  - RAS full push: wrap, overwrite oldest, count stays RAS_DEPTH.
//  - RAS empty pop: returnAddress=0, SIG_RET still asserted, count stays 0.
//  - Reset (async, any state): idValid=0, FSM=RUN, sp=0, count=0, RAS entries=0,
//    ID reg instr=0 (non-CF), so all SIG_* and addresses read 0 except
//    SIG_EQ (tracks rs1/rs2). Reset mid-FLUSH discards the pending squash.
// CONFIGURATION
//  CF_RAS_ERR_FLAGS_EN defined: extra outputs rasOverflow, rasUnderflow (1b each),
//   sticky, set on full-push / empty-pop, cleared only by reset.
//  Undefined: ports absent; wrap/underflow behaviour identical, unflagged.
// TESTING
//  1 reset low 2 cycles, instr=0 -> all SIG_* 0, idValid 0, returnAddress 0.
//  2 PC4=0x1000, instr J off26=0x40 -> SIG_Jump 1 one cycle, jumpAddress
//    0x00000100, next captured instr idValid 0, SIG_* 0.
//  3 BEQ imm16=0xFFFF, PC4=0x2004, rs1=rs2=5 -> SIG_BEQ 1, SIG_EQ 1,
//    branchAddress 0x2000, flush follows; rs2=6 -> no flush, idValid stays 1.
//  4 CALL at PC4=0x3004, then RET -> returnAddress 0x3004, SIG_RET 1.
//  5 9 CALLs (RAS_DEPTH=8) then 9 RETs -> 8 most-recent addrs LIFO, 9th
//    returnAddress 0; with CF_RAS_ERR_FLAGS_EN both flags 1.
//  6 reset asserted during FLUSH -> after release idValid follows first
//    capture (1), FSM RUN, RAS empty.

Source files
------------

// File: rtl/control_flow_resolver_if.sv
// Fetch <-> decode control-flow bus: fetched word/PC4 and register operands
// toward the resolver, redirect strobes and targets back toward fetch.
// Optional CF_RAS_ERR_FLAGS_EN adds the sticky RAS overflow/underflow flags.
interface control_flow_resolver_if #(
    parameter int unsigned AW = 32
);
    logic [31:0]   instruction;
    logic [AW-1:0] PC4;
    logic [AW-1:0] rs1Data;
    logic [AW-1:0] rs2Data;

    logic          SIG_Jump;
    logic          SIG_Call;
    logic          SIG_CALL_RS1;
    logic          SIG_RET;
    logic          SIG_BEQ;
    logic          SIG_BNE;
    logic          SIG_EQ;
    logic [AW-1:0] jumpAddress;
    logic [AW-1:0] branchAddress;
    logic [AW-1:0] callRs1Address;
    logic [AW-1:0] returnAddress;
    logic          idValid;
`ifdef CF_RAS_ERR_FLAGS_EN
    logic          rasOverflow;
    logic          rasUnderflow;
`endif

    // Fetch side
    modport master (
        output instruction, PC4, rs1Data, rs2Data,
        input  SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET, SIG_BEQ, SIG_BNE, SIG_EQ,
        input  jumpAddress, branchAddress, callRs1Address, returnAddress, idValid
`ifdef CF_RAS_ERR_FLAGS_EN
        , input rasOverflow, rasUnderflow
`endif
    );

    // Resolver side
    modport slave (
        input  instruction, PC4, rs1Data, rs2Data,
        output SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET, SIG_BEQ, SIG_BNE, SIG_EQ,
        output jumpAddress, branchAddress, callRs1Address, returnAddress, idValid
`ifdef CF_RAS_ERR_FLAGS_EN
        , output rasOverflow, rasUnderflow
`endif
    );
endinterface

// File: rtl/control_flow_resolver.sv
// Decode-stage control-flow resolver: latches the fetched instruction/PC4,
// decodes J/CALL/CALLR/RET/BEQ/BNE, drives redirect strobes and targets to
// fetch, owns a wrapping return-address stack and squashes the one wrong-path
// instruction behind a taken redirect.
// Optional feature macro: CF_RAS_ERR_FLAGS_EN (sticky RAS overflow/underflow flags).
module control_flow_resolver #(
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned AW        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    control_flow_resolver_if.slave  cf
);
    localparam int unsigned SPW = $clog2(RAS_DEPTH);
    localparam int unsigned CW  = SPW + 1;

    localparam logic [5:0] OP_J     = 6'h01;
    localparam logic [5:0] OP_CALL  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h04;
    localparam logic [5:0] OP_RET   = 6'h05;
    localparam logic [5:0] OP_CALLR = 6'h06;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc4;
    logic          id_valid, id_valid_d;

    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [SPW-1:0] ras_sp;
    logic [CW-1:0]  ras_cnt;

    logic [5:0]  op_c;
    logic [15:0] imm16_c;
    logic [25:0] off26_c;
    logic        is_j_c, is_call_c, is_callr_c, is_ret_c, is_beq_c, is_bne_c;
    logic        eq_c, taken_c, push_c, pop_c;

    // Field extraction and valid-gated opcode decode of the ID register
    always_comb begin
        op_c       = id_instr[31:26];
        imm16_c    = id_instr[15:0];
        off26_c    = id_instr[25:0];
        eq_c       = (cf.rs1Data == cf.rs2Data);
        is_j_c     = id_valid && (op_c == OP_J);
        is_call_c  = id_valid && (op_c == OP_CALL);
        is_callr_c = id_valid && (op_c == OP_CALLR);
        is_ret_c   = id_valid && (op_c == OP_RET);
        is_beq_c   = id_valid && (op_c == OP_BEQ);
        is_bne_c   = id_valid && (op_c == OP_BNE);
        taken_c    = is_j_c || is_call_c || is_callr_c || is_ret_c ||
                     (is_beq_c && eq_c) || (is_bne_c && !eq_c);
        push_c     = is_call_c || is_callr_c;
        pop_c      = is_ret_c;
    end

    // Strobes, targets and stack top toward fetch
    always_comb begin
        cf.SIG_Jump       = is_j_c;
        cf.SIG_Call       = is_call_c;
        cf.SIG_CALL_RS1   = is_callr_c;
        cf.SIG_RET        = is_ret_c;
        cf.SIG_BEQ        = is_beq_c;
        cf.SIG_BNE        = is_bne_c;
        cf.SIG_EQ         = eq_c;
        cf.idValid        = id_valid;
        cf.jumpAddress    = {id_pc4[AW-1:28], off26_c, 2'b00};
        cf.branchAddress  = id_pc4 + {{(AW-18){imm16_c[15]}}, imm16_c, 2'b00};
        cf.callRs1Address = cf.rs1Data;
        cf.returnAddress  = (ras_cnt != '0) ? ras_mem[ras_sp - SPW'(1)] : '0;
    end

    // Next state: a taken redirect squashes exactly the next capture
    always_comb begin
        state_d    = state_q;
        id_valid_d = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (taken_c) begin
                    state_d    = ST_FLUSH;
                    id_valid_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            id_instr <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_instr <= cf.instruction;
            id_pc4   <= cf.PC4;
            id_valid <= id_valid_d;
        end
    end

    // Return-address stack: full push overwrites oldest, empty pop is a no-op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (push_c) begin
            ras_mem[ras_sp] <= id_pc4;
            ras_sp          <= ras_sp + SPW'(1);
            if (ras_cnt != CW'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + CW'(1);
            end
        end else if (pop_c && (ras_cnt != '0)) begin
            ras_sp  <= ras_sp - SPW'(1);
            ras_cnt <= ras_cnt - CW'(1);
        end
    end

`ifdef CF_RAS_ERR_FLAGS_EN
    logic ras_ovf_q, ras_unf_q;

    // Sticky stack error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
        end else begin
            if (push_c && (ras_cnt == CW'(RAS_DEPTH))) begin
                ras_ovf_q <= 1'b1;
            end
            if (pop_c && (ras_cnt == '0)) begin
                ras_unf_q <= 1'b1;
            end
        end
    end

    assign cf.rasOverflow  = ras_ovf_q;
    assign cf.rasUnderflow = ras_unf_q;
`endif
endmodule

// File: tb/tb_control_flow_resolver.sv
// Directed bench for control_flow_resolver: vector table plus hand sequences
// for RAS wrap/underflow and reset during a flush.
module tb_control_flow_resolver;
    logic clk;
    logic reset;

    control_flow_resolver_if #(.AW(32)) cf ();

    control_flow_resolver #(.RAS_DEPTH(8), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cf    (cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        valid;
        logic [5:0]  sig;   // {Jump, Call, CALL_RS1, RET, BEQ, BNE}
        logic        eq;
        logic [31:0] jaddr;
        logic [31:0] baddr;
        logic [31:0] raddr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [25:0] f);
        return {op, f};
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc4,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic valid, input logic [5:0] sig, input logic eq,
                                 input logic [31:0] jaddr, input logic [31:0] baddr,
                                 input logic [31:0] raddr);
        vec_t v;
        v.instr = instr; v.pc4 = pc4; v.rs1 = rs1; v.rs2 = rs2;
        v.valid = valid; v.sig = sig; v.eq = eq;
        v.jaddr = jaddr; v.baddr = baddr; v.raddr = raddr;
        return v;
    endfunction

    function automatic logic [5:0] sigs();
        return {cf.SIG_Jump, cf.SIG_Call, cf.SIG_CALL_RS1, cf.SIG_RET, cf.SIG_BEQ, cf.SIG_BNE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Present instr/PC4 for the next capture edge, then the operands of the latched instr
    task automatic cycle(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        cf.instruction = instr;
        cf.PC4         = pc4;
        @(posedge clk);
        #1;
        cf.rs1Data = rs1;
        cf.rs2Data = rs2;
        #1;
    endtask

    initial begin
        logic [31:0] exp_r;
        reset          = 1'b0;
        cf.instruction = '0;
        cf.PC4         = '0;
        cf.rs1Data     = '0;
        cf.rs2Data     = '0;

        // Vector table: J, squash, BEQ taken/not taken, BNE, CALL/RET, CALLR, wrap cases
        vecs.push_back(mkv(enc(6'h01, 26'h40), 32'h1000, 1, 2, 1, 6'b100000, 0, 32'h100, 32'h1100, 0));
        vecs.push_back(mkv(NOP, 32'h1004, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h1004, 0));
        vecs.push_back(mkv(enc(6'h03, 26'hFFFF), 32'h2004, 5, 5, 1, 6'b000010, 1, 32'h3FFFC, 32'h2000, 0));
        vecs.push_back(mkv(NOP, 32'h2008, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h2008, 0));
        vecs.push_back(mkv(enc(6'h03, 26'hFFFF), 32'h200C, 5, 6, 1, 6'b000010, 0, 32'h3FFFC, 32'h2008, 0));
        vecs.push_back(mkv(NOP, 32'h2010, 1, 2, 1, 6'b000000, 0, 32'h0, 32'h2010, 0));
        vecs.push_back(mkv(enc(6'h04, 26'h0004), 32'h2014, 3, 3, 1, 6'b000001, 1, 32'h10, 32'h2024, 0));
        vecs.push_back(mkv(NOP, 32'h2018, 1, 2, 1, 6'b000000, 0, 32'h0, 32'h2018, 0));
        vecs.push_back(mkv(enc(6'h02, 26'h100), 32'h3004, 1, 2, 1, 6'b010000, 0, 32'h400, 32'h3404, 0));
        vecs.push_back(mkv(NOP, 32'h3008, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h3008, 32'h3004));
        vecs.push_back(mkv(enc(6'h05, 26'h0), 32'h4004, 1, 2, 1, 6'b000100, 0, 32'h0, 32'h4004, 32'h3004));
        vecs.push_back(mkv(NOP, 32'h4008, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h4008, 0));
        vecs.push_back(mkv(NOP, 32'h400C, 1, 2, 1, 6'b000000, 0, 32'h0, 32'h400C, 0));
        vecs.push_back(mkv(enc(6'h06, 26'h0), 32'h5004, 32'h8888, 1, 1, 6'b001000, 0, 32'h0, 32'h5004, 0));
        vecs.push_back(mkv(NOP, 32'h5008, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h5008, 32'h5004));
        vecs.push_back(mkv(enc(6'h05, 26'h0), 32'h6004, 1, 2, 1, 6'b000100, 0, 32'h0, 32'h6004, 32'h5004));
        vecs.push_back(mkv(NOP, 32'h6008, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h6008, 0));
        vecs.push_back(mkv(enc(6'h07, 26'h0), 32'h7000, 1, 2, 1, 6'b000000, 0, 32'h0, 32'h7000, 0));
        vecs.push_back(mkv(enc(6'h01, 26'h3FFFFFF), 32'hF0001000, 1, 2, 1, 6'b100000, 0, 32'hFFFFFFFC, 32'hF0000FFC, 0));
        vecs.push_back(mkv(NOP, 32'h0, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mkv(enc(6'h04, 26'h7FFF), 32'hFFFFFFF0, 1, 2, 1, 6'b000001, 0, 32'hF001FFFC, 32'h0001FFEC, 0));
        vecs.push_back(mkv(NOP, 32'h10, 1, 2, 0, 6'b000000, 0, 32'h0, 32'h10, 0));
        vecs.push_back(mkv(NOP, 32'h14, 1, 2, 1, 6'b000000, 0, 32'h0, 32'h14, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_idValid", 32'(cf.idValid), 0);
        chk("rst_sig", 32'(sigs()), 0);
        chk("rst_eq", 32'(cf.SIG_EQ), 1);
        chk("rst_jaddr", cf.jumpAddress, 0);
        chk("rst_baddr", cf.branchAddress, 0);
        chk("rst_raddr", cf.returnAddress, 0);
`ifdef CF_RAS_ERR_FLAGS_EN
        chk("rst_flags", 32'({cf.rasOverflow, cf.rasUnderflow}), 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].instr, vecs[i].pc4, vecs[i].rs1, vecs[i].rs2);
            chk($sformatf("v%0d_idValid", i), 32'(cf.idValid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_sig", i), 32'(sigs()), 32'(vecs[i].sig));
            chk($sformatf("v%0d_eq", i), 32'(cf.SIG_EQ), 32'(vecs[i].eq));
            chk($sformatf("v%0d_jaddr", i), cf.jumpAddress, vecs[i].jaddr);
            chk($sformatf("v%0d_baddr", i), cf.branchAddress, vecs[i].baddr);
            chk($sformatf("v%0d_raddr", i), cf.returnAddress, vecs[i].raddr);
            chk($sformatf("v%0d_callrs1", i), cf.callRs1Address, vecs[i].rs1);
        end

        // Nine CALLs into an 8-deep stack, then nine RETs
        for (int i = 1; i <= 9; i++) begin
            cycle(enc(6'h02, 26'h0), 32'h100 * i + 4, 1, 2);
            chk($sformatf("ovf_call%0d", i), 32'(cf.SIG_Call), 1);
            cycle(NOP, 32'hA0, 1, 2);
        end
`ifdef CF_RAS_ERR_FLAGS_EN
        chk("ovf_flag", 32'({cf.rasOverflow, cf.rasUnderflow}), 32'b10);
`endif
        for (int k = 0; k < 9; k++) begin
            exp_r = (k < 8) ? (32'h100 * (9 - k) + 4) : 32'h0;
            cycle(enc(6'h05, 26'h0), 32'hB0, 1, 2);
            chk($sformatf("lifo_ret%0d_sig", k), 32'(cf.SIG_RET), 1);
            chk($sformatf("lifo_ret%0d_raddr", k), cf.returnAddress, exp_r);
            cycle(NOP, 32'hB4, 1, 2);
        end
`ifdef CF_RAS_ERR_FLAGS_EN
        chk("unf_flag", 32'({cf.rasOverflow, cf.rasUnderflow}), 32'b11);
`endif
        // Empty pop left count at zero: one push/pop round-trips
        cycle(enc(6'h02, 26'h0), 32'hABC4, 1, 2);
        cycle(NOP, 32'hC0, 1, 2);
        chk("post_unf_push", cf.returnAddress, 32'hABC4);
        cycle(enc(6'h05, 26'h0), 32'hC4, 1, 2);
        chk("post_unf_ret", cf.returnAddress, 32'hABC4);
        cycle(NOP, 32'hC8, 1, 2);
        chk("post_unf_empty", cf.returnAddress, 0);

        // Reset asserted while a squash is pending
        cycle(enc(6'h02, 26'h0), 32'h9004, 1, 2);
        cycle(NOP, 32'h9008, 1, 2);
        cycle(NOP, 32'h900C, 1, 2);
        cycle(enc(6'h01, 26'h10), 32'h9100, 1, 2);
        chk("flush_jump", 32'(cf.SIG_Jump), 1);
        cycle(NOP, 32'h9104, 1, 2);
        chk("flush_squash", 32'(cf.idValid), 0);
        chk("flush_ras", cf.returnAddress, 32'h9004);
        reset = 1'b0;
        #1;
        chk("midrst_idValid", 32'(cf.idValid), 0);
        chk("midrst_raddr", cf.returnAddress, 0);
        chk("midrst_sig", 32'(sigs()), 0);
        @(negedge clk);
        reset = 1'b1;
        cycle(NOP, 32'hA000, 1, 2);
        chk("postrst_idValid", 32'(cf.idValid), 1);
        chk("postrst_raddr", cf.returnAddress, 0);
`ifdef CF_RAS_ERR_FLAGS_EN
        chk("postrst_flags", 32'({cf.rasOverflow, cf.rasUnderflow}), 0);
`endif
        cycle(enc(6'h01, 26'h20), 32'hA004, 1, 2);
        chk("postrst_jump", 32'(cf.SIG_Jump), 1);
        chk("postrst_jaddr", cf.jumpAddress, 32'h80);
        cycle(NOP, 32'hA008, 1, 2);
        chk("postrst_squash", 32'(cf.idValid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
